// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode seven-segment scanner with blanking, PWM dimming and frame snapshots
module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [8*NUM_DIGITS-1:0]       segValues,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [BRIGHT_BITS-1:0]        brightness,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    seg,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_start
);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam int TW = CW + 1;
    localparam int BW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [TW-1:0] STEP = TW'(DWELL_CYCLES >> BRIGHT_BITS);
    localparam logic [CW-1:0] DLAST = CW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLAST = BW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [SW-1:0] SLAST = SW'(NUM_DIGITS - 1);
    typedef enum logic {DRIVE, BLANK} state_t;
    state_t state;
    logic [SW-1:0] slot, nslot;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic [8*NUM_DIGITS-1:0] sh_seg, cur_seg;
    logic [NUM_DIGITS-1:0] sh_en, cur_en;
    logic [BRIGHT_BITS-1:0] sh_br, cur_br;
    logic snap, lit;
    always_comb begin
        snap = state == DRIVE && slot == '0 && cnt == '0;
        cur_seg = snap ? segValues : sh_seg;
        cur_en = snap ? digit_en : sh_en;
        cur_br = snap ? brightness : sh_br;
        lit = state == DRIVE && cur_en[slot] && (&cur_br || TW'(cnt) < TW'(cur_br) * STEP);
        nslot = slot == SLAST ? '0 : slot + SW'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DRIVE;
            slot <= '0;
            cnt <= '0;
            bcnt <= '0;
            sh_seg <= '1;
            sh_en <= '1;
            sh_br <= '1;
            an <= '1;
            seg <= 8'hFF;
            digit_idx <= '0;
            frame_start <= 1'b0;
        end else begin
            if (snap) begin
                sh_seg <= segValues;
                sh_en <= digit_en;
                sh_br <= brightness;
            end
            an <= lit ? ~(NUM_DIGITS'(1) << slot) : '1;
            seg <= lit ? cur_seg[8*slot +: 8] : 8'hFF;
            digit_idx <= slot;
            frame_start <= snap;
            if (state == DRIVE) begin
                cnt <= cnt == DLAST ? '0 : cnt + CW'(1);
                if (cnt == DLAST) begin
                    if (BLANK_CYCLES > 0) state <= BLANK;
                    else slot <= nslot;
                end
            end else begin
                bcnt <= bcnt == BLAST ? '0 : bcnt + BW'(1);
                if (bcnt == BLAST) begin
                    state <= DRIVE;
                    slot <= nslot;
                end
            end
        end
    end
endmodule
